// File: rtl/rcb_spi_master.sv
// Single-word SPI master: programmable clock polarity/phase, SCLK divider, chip-select
// setup/hold/gap timing and abort. Every output comes straight from a flop.
module rcb_spi_master #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CLK_DIV  = 10,
    parameter int unsigned CPOL     = 0,
    parameter int unsigned CPHA     = 0,
    parameter int unsigned N_CS     = 1,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4,
    localparam int unsigned CS_W    = (N_CS > 1) ? $clog2(N_CS) : 1
) (
    input  logic              clk_100m,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic [N_CS-1:0]   cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned BCW     = $clog2(DATA_W) + 1;
    localparam int unsigned MAX_AB  = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
    localparam int unsigned MAX_CD  = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic        IDLE_LVL = (CPOL != 0);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StShift = 3'd2;
    localparam logic [2:0] StHold  = 3'd3;
    localparam logic [2:0] StGap   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic [N_CS-1:0]   cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              tick;
    logic              leading;
    logic              sample_edge;
    logic [N_CS-1:0]   sel_onehot;

    assign tick        = (cnt_q == '0);
    // sclk still at its idle level means the next toggle is a leading edge
    assign leading     = (sclk_q == IDLE_LVL);
    assign sample_edge = (CPHA != 0) ? !leading : leading;

    // Out-of-range selects fall back to chip select 0
    always_comb begin
        sel_onehot = '0;
        for (int unsigned i = 0; i < N_CS; i++) begin
            sel_onehot[i] = (32'(cs_sel) == i);
        end
        if (sel_onehot == '0) begin
            sel_onehot[0] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSetup;
                    cnt_d     = CNT_W'(CS_SETUP - 1);
                    bit_cnt_d = BCW'(DATA_W);
                    rx_sh_d   = '0;
                    cs_n_d    = ~sel_onehot;
                    sclk_d    = IDLE_LVL;
                    // CPHA=0 slaves sample on the first edge, so the MSB leads cs_n
                    if (CPHA == 0) begin
                        mosi_d = tx_data[DATA_W-1];
                        tx_d   = {tx_data[DATA_W-2:0], 1'b0};
                    end else begin
                        mosi_d = 1'b0;
                        tx_d   = tx_data;
                    end
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StShift;
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StShift: begin
                if (tick) begin
                    cnt_d  = CNT_W'(CLK_DIV - 1);
                    sclk_d = ~sclk_q;
                    if (sample_edge) begin
                        rx_sh_d   = {rx_sh_q[DATA_W-2:0], miso};
                        bit_cnt_d = bit_cnt_q - BCW'(1);
                    end else begin
                        mosi_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    // Finish on the final trailing edge so sclk is back at idle level
                    if (!leading && bit_cnt_d == '0) begin
                        state_d = StHold;
                        cnt_d   = CNT_W'(CS_HOLD - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StHold: begin
                if (tick) begin
                    state_d   = StGap;
                    cnt_d     = CNT_W'(CS_GAP - 1);
                    cs_n_d    = '1;
                    sclk_d    = IDLE_LVL;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (tick) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cs_n_d  = '1;
                sclk_d  = IDLE_LVL;
                mosi_d  = 1'b0;
            end
        endcase

        // Abort overrides any normal completion in the same cycle
        if (abort && (state_q == StSetup || state_q == StShift || state_q == StHold)) begin
            state_d   = StGap;
            cnt_d     = CNT_W'(CS_GAP - 1);
            sclk_d    = IDLE_LVL;
            cs_n_d    = '1;
            mosi_d    = 1'b0;
            done_d    = 1'b0;
            rx_data_d = rx_data_q;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= IDLE_LVL;
            cs_n_q    <= '1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_rcb_spi_master.sv
// Bench for rcb_spi_master: mode-0 loopback instance with five chip selects and a
// mode-3 instance driven by a behavioural slave.
module tb_rcb_spi_master;

    logic clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;
    logic rst_n = 1'b1;

    // Instance 0: mode 0, 8-bit, loopback
    logic       start0 = 1'b0, abort0 = 1'b0;
    logic [7:0] tx0 = '0;
    logic [2:0] sel0 = '0;
    logic       busy0, done0, sclk0, mosi0, miso0;
    logic [7:0] rx0;
    logic [4:0] cs_n0;
    assign miso0 = mosi0;

    // Instance 1: mode 3, 16-bit, slave model
    logic        start1 = 1'b0, abort1 = 1'b0;
    logic [15:0] tx1 = '0;
    logic [0:0]  sel1 = '0;
    logic        busy1, done1, sclk1, mosi1;
    logic        miso1 = 1'b0;
    logic [15:0] rx1;
    logic [0:0]  cs_n1;

    rcb_spi_master #(
        .DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .N_CS(5),
        .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)
    ) u_dut0 (
        .clk_100m(clk_100m), .rst_n(rst_n), .start(start0), .tx_data(tx0),
        .cs_sel(sel0), .abort(abort0), .busy(busy0), .done(done0), .rx_data(rx0),
        .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso0)
    );

    rcb_spi_master #(
        .DATA_W(16), .CLK_DIV(3), .CPOL(1), .CPHA(1), .N_CS(1),
        .CS_SETUP(1), .CS_HOLD(3), .CS_GAP(2)
    ) u_dut1 (
        .clk_100m(clk_100m), .rst_n(rst_n), .start(start1), .tx_data(tx1),
        .cs_sel(sel1), .abort(abort1), .busy(busy1), .done(done1), .rx_data(rx1),
        .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1)
    );

    // Mode-3 slave: shifts out its word MSB first on every leading (falling) sclk edge
    logic [15:0] slave_word = '0;
    int          slv_idx = 0;
    always @(posedge cs_n1[0] or negedge sclk1) begin
        if (cs_n1[0]) begin
            slv_idx = 0;
        end else if (slv_idx < 16) begin
            miso1   = slave_word[15 - slv_idx];
            slv_idx = slv_idx + 1;
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [15:0] last_rx [2] = '{16'h0, 16'h0};
    logic        o_sclk, o_mosi, o_done, o_busy;
    logic [15:0] o_rx;
    logic [4:0]  o_cs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int d);
        if (d == 0) begin
            o_sclk = sclk0; o_mosi = mosi0; o_done = done0; o_busy = busy0;
            o_rx = {8'h00, rx0}; o_cs = cs_n0;
        end else begin
            o_sclk = sclk1; o_mosi = mosi1; o_done = done1; o_busy = busy1;
            o_rx = rx1; o_cs = {4'hF, cs_n1};
        end
    endtask

    task automatic strobe(input int d, input logic st, input logic ab,
                          input logic [15:0] txv, input logic [2:0] selv);
        if (d == 0) begin
            start0 = st; abort0 = ab;
            if (st) begin tx0 = txv[7:0]; sel0 = selv; end
        end else begin
            start1 = st; abort1 = ab;
            if (st) begin tx1 = txv; sel1 = selv[0]; end
        end
    endtask

    task automatic release_strobes(input int d);
        if (d == 0) begin start0 = 1'b0; abort0 = 1'b0; end
        else begin start1 = 1'b0; abort1 = 1'b0; end
    endtask

    // One transfer from idle back to idle, checked against the timing/data rules.
    task automatic transfer(input int d, input logic [15:0] tx, input logic [2:0] sel,
                            input int abort_at, input int stray_at, input bit with_abort);
        int          w, dv, s, h, g, cs_low, abort_cs, rises, dones, cyc, n, nbits;
        logic [15:0] mask, got_mosi, exp_rx, exp_bits;
        logic [4:0]  exp_cs, cs_seen;
        logic        cpol, prev_sclk;
        bit          ab_exp, finished;
        w  = (d == 1) ? 16 : 8;
        dv = (d == 1) ? 3 : 2;
        s  = (d == 1) ? 1 : 2;
        h  = (d == 1) ? 3 : 2;
        g  = (d == 1) ? 2 : 4;
        mask     = (d == 1) ? 16'hFFFF : 16'h00FF;
        cpol     = (d == 1);
        ab_exp   = (abort_at != 0);
        exp_cs   = (d == 0 && sel < 5) ? ~(5'd1 << sel) : 5'b11110;
        exp_rx   = (d == 1) ? slave_word : (tx & mask);
        nbits    = ab_exp ? abort_at : w;
        exp_bits = (tx & mask) >> (w - nbits);

        @(negedge clk_100m);
        sample(d);
        chk("idle_sclk", o_sclk, cpol);
        chk("idle_busy", o_busy, 1'b0);
        strobe(d, 1'b1, with_abort, tx, sel);
        @(negedge clk_100m);
        release_strobes(d);

        cs_low = 0; abort_cs = -1; rises = 0; dones = 0; cyc = 0;
        got_mosi = '0; cs_seen = exp_cs; prev_sclk = cpol; finished = 0;
        while (!finished && cyc < 3000) begin
            sample(d);
            if (o_done) dones++;
            if (o_cs == 5'h1F) begin
                finished = 1;
            end else begin
                cs_low++;
                if (o_cs != exp_cs) cs_seen = o_cs;
                if (o_sclk && !prev_sclk) begin
                    rises++;
                    got_mosi = {got_mosi[14:0], o_mosi};
                    if (rises == abort_at) begin
                        abort_cs = cs_low;
                        strobe(d, 1'b0, 1'b1, tx, sel);
                    end
                    if (rises == stray_at) strobe(d, 1'b1, 1'b0, 16'hFFFF, sel);
                end
                prev_sclk = o_sclk;
                @(negedge clk_100m);
                release_strobes(d);
                cyc++;
            end
        end

        chk("cs_rise_seen", finished, 1'b1);
        chk("cs_select", cs_seen, exp_cs);
        chk("cs_low_cycles", cs_low, ab_exp ? abort_cs : (s + 2 * w * dv + h));
        chk("sclk_rises", rises, nbits);
        chk("mosi_bits", got_mosi & ((16'h1 << nbits) - 16'h1), exp_bits);
        chk("done_at_cs_rise", o_done, !ab_exp);
        chk("done_count", dones, ab_exp ? 0 : 1);
        chk("rx_data", o_rx, ab_exp ? last_rx[d] : exp_rx);
        chk("sclk_after", o_sclk, cpol);
        if (ab_exp) chk("mosi_after_abort", o_mosi, 1'b0);

        n = 0;
        while (o_busy && n < 60) begin
            n++;
            @(negedge clk_100m);
            sample(d);
        end
        chk("gap_busy_cycles", n, g);
        chk("rx_after_gap", o_rx, ab_exp ? last_rx[d] : exp_rx);
        if (!ab_exp) last_rx[d] = exp_rx;
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #10;
        sample(0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_rx", o_rx, 16'h0);
        chk("rst_sclk0", o_sclk, 1'b0);
        chk("rst_cs0", o_cs, 5'h1F);
        chk("rst_mosi", o_mosi, 1'b0);
        sample(1);
        chk("rst_sclk1", o_sclk, 1'b1);
        chk("rst_cs1", o_cs, 5'h1F);
        #11 rst_n = 1'b1;

        transfer(0, 16'h00A5, 3'd0, 0, 0, 1'b0);
        transfer(0, 16'h003C, 3'd2, 0, 4, 1'b0);
        transfer(0, 16'h0096, 3'd5, 0, 0, 1'b0);
        transfer(0, 16'($urandom_range(0, 255)), 3'd1, 3, 0, 1'b0);
        transfer(0, 16'($urandom_range(0, 255)), 3'd3, 0, 0, 1'b1);
        slave_word = 16'h3C5A;
        transfer(1, 16'($urandom), 3'd0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            transfer(0, 16'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 0, 0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            slave_word = 16'($urandom);
            transfer(1, 16'($urandom), 3'd0, 0, 0, 1'b0);
        end
        transfer(0, 16'h00F0, 3'd4, 0, 0, 1'b0);

        // Reset pulse mid-SHIFT, between clock edges
        @(negedge clk_100m);
        strobe(0, 1'b1, 1'b0, 16'h00C3, 3'd1);
        @(negedge clk_100m);
        release_strobes(0);
        repeat (12) @(negedge clk_100m);
        #1 rst_n = 1'b0;
        #1 sample(0);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_done", o_done, 1'b0);
        chk("midrst_rx", o_rx, 16'h0);
        chk("midrst_sclk", o_sclk, 1'b0);
        chk("midrst_cs", o_cs, 5'h1F);
        chk("midrst_mosi", o_mosi, 1'b0);
        #2 rst_n = 1'b1;
        last_rx[0] = '0;
        last_rx[1] = '0;
        n = 0;
        repeat (8) begin
            @(negedge clk_100m);
            sample(0);
            if (o_done || o_busy || o_cs != 5'h1F) n++;
        end
        chk("postrst_quiet", n, 0);
        transfer(0, 16'h005A, 3'd0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
